// File: rtl/mem_bus_pkg.sv
// Shared definitions for the read_mem/write_mem word-access target.
// Holds the default bus widths, the responder FSM state encoding and a
// range-check helper used when a request is accepted.
package mem_bus_pkg;

  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_BE_W        = DEF_DATA_W / 8;
  localparam int DEF_DEPTH       = 1024;
  localparam int DEF_WAIT_STATES = 2;

  // Responder FSM encoding: IDLE -> WAIT -> RESP -> IDLE
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  // True when a zero-extended word address lands inside the implemented
  // array. DEPTH need not be a power of two, so this is a full compare.
  function automatic logic addr_in_range(input logic [31:0] addr, input int depth);
    return addr < 32'(depth);
  endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port synchronous word array behind mem_responder.
// Ports:
//   clk    - rising-edge clock
//   en     - access strobe for this cycle
//   we     - 1 = write enabled bytes, 0 = read the addressed word
//   be     - per-byte write enables
//   addr   - word index into the array
//   wdata  - write data
//   rdata  - word captured by the most recent read; holds between reads
// The array and the read register are deliberately not reset.
module mem_responder_ram
  import mem_bus_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BE_W   = DATA_W / 8,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Writes leave the read register alone so it always reflects the last
  // read, keeping a held response stable.
  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) begin
      rdata_d = mem[addr];
    end
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (en && we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be[b]) begin
          mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Target end of the read_mem/write_mem word-access protocol.
// Accepts one single-word request at a time, waits WAIT_STATES cycles,
// commits or fetches against an internal word array and returns exactly
// one response per request.
// Ports:
//   clk, rst_n           - clock and asynchronous active-low reset
//   req_valid/req_ready  - request handshake (ready only while idle)
//   req_write            - 1 = write_mem, 0 = read_mem
//   req_addr             - word address, checked against DEPTH
//   req_wdata, req_be    - write data and byte enables
//   rsp_valid/rsp_ready  - response handshake
//   rsp_rdata            - read data, 0 for writes and errors
//   rsp_err              - address was out of range
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               req_ready_q, req_ready_d;
  logic               write_q, write_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [BE_W-1:0]    be_q, be_d;
  logic               oor_q, oor_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic               rd_sel_q, rd_sel_d;
  logic               ram_en;
  logic [DATA_W-1:0]  ram_rdata;

  // Request latch, wait counter and response flags.
  // RESP spends its first cycle performing the array access (write commit
  // or read fetch) with rsp_valid still low; rsp_valid then rises on the
  // same edge that completes the access, giving WAIT_STATES+1 cycles from
  // accept to response. A reset before that edge discards the request.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    oor_d       = oor_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rd_sel_d    = rd_sel_q;
    ram_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          write_d = req_write;
          idx_d   = req_addr[IDX_W-1:0];
          wdata_d = req_wdata;
          be_d    = req_be;
          oor_d   = !addr_in_range(32'(req_addr), DEPTH);
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = 8'(WAIT_STATES - 1);
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RESP: begin
        if (!rsp_valid_q) begin
          ram_en      = !oor_q;
          rsp_valid_d = 1'b1;
          rsp_err_d   = oor_q;
          rd_sel_d    = !oor_q && !write_q;
        end else if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rd_sel_d    = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  // All control and response state clears asynchronously; the array does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      write_q     <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      oor_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_sel_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      write_q     <= write_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      oor_q       <= oor_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rd_sel_q    <= rd_sel_d;
    end
  end

  mem_responder_ram #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .BE_W  (BE_W),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (write_q),
    .be   (be_q),
    .addr (idx_q),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  // The RAM read register is not reset, so read data is only exposed while
  // a read response is actually being presented.
  assign rsp_rdata = rd_sel_q ? ram_rdata : '0;
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder. Two instances are exercised:
// index 0 with WAIT_STATES=2 and index 1 with WAIT_STATES=0. Expected
// responses come from a byte-enable-aware memory model and pass through a
// scoreboard queue between request and response.
module tb_mem_responder;

  localparam int DEPTH = 1024;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [15:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [15:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  exp_t        sb [$];
  logic [31:0] model [int];

  mem_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH(DEPTH), .WAIT_STATES(2)) dut_ws2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  mem_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH(DEPTH), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "[TB] watchdog");
  end

  function automatic int exp_lat(input int d);
    return (d == 0) ? 3 : 1;
  endfunction

  function automatic op_t mk(input logic wr, input logic [15:0] a, input logic [31:0] wd, input logic [3:0] be);
    op_t o;
    o.wr = wr; o.a = a; o.wd = wd; o.be = be;
    return o;
  endfunction

  // Reference behaviour: out-of-range -> err, no access; writes merge enabled bytes.
  function automatic exp_t predict(input int d, input op_t o);
    exp_t        e;
    int          k;
    logic [31:0] w;
    e.rdata = '0;
    e.err   = 1'b0;
    k = d * 65536 + int'(o.a);
    if (int'(o.a) >= DEPTH) begin
      e.err = 1'b1;
    end else if (o.wr) begin
      w = model.exists(k) ? model[k] : 32'h0;
      for (int b = 0; b < 4; b++) if (o.be[b]) w[b*8 +: 8] = o.wd[b*8 +: 8];
      model[k] = w;
    end else begin
      e.rdata = model.exists(k) ? model[k] : 32'h0;
    end
    return e;
  endfunction

  task automatic drive_req(input int d, input op_t o, output bit ok, output int acc);
    int budget = 0;
    ok  = 1'b0;
    acc = -1;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_write[d] = o.wr;
    req_addr[d]  = o.a;
    req_wdata[d] = o.wd;
    req_be[d]    = o.be;
    while (!req_ready[d] && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (req_ready[d]) begin
      @(posedge clk);
      #1;
      acc = cyc;
      ok  = 1'b1;
    end
    req_valid[d] = 1'b0;
  endtask

  task automatic collect(input int d, input int acc, output bit ok, output logic [31:0] rd,
                         output logic er, output int lat);
    int budget = 0;
    ok = 1'b0; rd = '0; er = 1'b0; lat = -1;
    @(negedge clk);
    while (!rsp_valid[d] && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (rsp_valid[d]) begin
      ok  = 1'b1;
      rd  = rsp_rdata[d];
      er  = rsp_err[d];
      lat = cyc - acc;
      rsp_ready[d] = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready[d] = 1'b0;
    end
  endtask

  task automatic transact(input int d, input op_t o, output bit ok, output logic [31:0] rd,
                          output logic er, output int lat);
    int acc;
    bit ok_req;
    drive_req(d, o, ok_req, acc);
    if (ok_req) collect(d, acc, ok, rd, er, lat);
    else begin ok = 1'b0; rd = '0; er = 1'b0; lat = -1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0; req_be[d] = '0; rsp_ready[d] = 1'b0;
    end
    #1 rst_n = 1'b0;
    #2;
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if ({req_ready[d], rsp_valid[d], rsp_err[d], rsp_rdata[d]} !== 35'd0) begin
        n_bad++;
        $display("[TB] FAIL reset_outputs[%0d]: got ready=%b valid=%b err=%b rdata=0x%08h, expected all 0",
                 d, req_ready[d], rsp_valid[d], rsp_err[d], rsp_rdata[d]);
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (req_ready[0] !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_release_ready: got %b, expected 0 before first edge", req_ready[0]);
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (req_ready[d] !== 1'b1) begin
        n_bad++;
        $display("[TB] FAIL reset_ready_rise[%0d]: got %b, expected 1", d, req_ready[d]);
      end
    end
  endtask

  task automatic run_table(input int d, input string tag, input op_t ops [$]);
    bit          ok;
    logic [31:0] rd;
    logic        er;
    int          lat;
    exp_t        e;
    foreach (ops[i]) begin
      sb.push_back(predict(d, ops[i]));
      transact(d, ops[i], ok, rd, er, lat);
      e = sb.pop_front();
      n_vec++;
      if (!ok) begin
        n_bad++;
        $display("[TB] FAIL %s[%0d] handshake: got timeout, expected response", tag, i);
        continue;
      end
      n_vec++;
      if (rd !== e.rdata) begin
        n_bad++;
        $display("[TB] FAIL %s[%0d] rdata: got 0x%08h, expected 0x%08h", tag, i, rd, e.rdata);
      end
      n_vec++;
      if (er !== e.err) begin
        n_bad++;
        $display("[TB] FAIL %s[%0d] err: got %b, expected %b", tag, i, er, e.err);
      end
      n_vec++;
      if (lat != exp_lat(d)) begin
        n_bad++;
        $display("[TB] FAIL %s[%0d] latency: got %0d, expected %0d", tag, i, lat, exp_lat(d));
      end
    end
  endtask

  task automatic test_write_read();
    op_t ops [$];
    ops.push_back(mk(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF));
    ops.push_back(mk(1'b0, 16'h0010, 32'h0, 4'h0));
    run_table(0, "write_read", ops);
  endtask

  task automatic test_byte_enable();
    op_t ops [$];
    ops.push_back(mk(1'b1, 16'h0010, 32'h11223344, 4'h5));
    ops.push_back(mk(1'b0, 16'h0010, 32'h0, 4'h0));
    ops.push_back(mk(1'b1, 16'h0010, 32'hFFFFFFFF, 4'h0));
    ops.push_back(mk(1'b0, 16'h0010, 32'h0, 4'h0));
    run_table(0, "byte_enable", ops);
    n_vec++;
    if (model[16] !== 32'hDE22BE44) begin
      n_bad++;
      $display("[TB] FAIL byte_enable_model: got 0x%08h, expected 0xDE22BE44", model[16]);
    end
  endtask

  task automatic test_out_of_range();
    op_t ops [$];
    ops.push_back(mk(1'b1, 16'h03FF, 32'h55AA1234, 4'hF));
    ops.push_back(mk(1'b1, 16'h0000, 32'hA5A5C3C3, 4'hF));
    ops.push_back(mk(1'b0, 16'h0400, 32'h0, 4'h0));
    ops.push_back(mk(1'b1, 16'hFFFF, 32'h12345678, 4'hF));
    ops.push_back(mk(1'b1, 16'h0400, 32'h87654321, 4'hF));
    ops.push_back(mk(1'b0, 16'h03FF, 32'h0, 4'h0));
    ops.push_back(mk(1'b0, 16'h0000, 32'h0, 4'h0));
    run_table(0, "out_of_range", ops);
  endtask

  task automatic test_backpressure();
    bit   ok;
    int   acc;
    int   budget = 0;
    exp_t e;
    op_t  rd_op = mk(1'b0, 16'h0010, 32'h0, 4'h0);
    op_t  q [$];
    sb.push_back(predict(0, rd_op));
    drive_req(0, rd_op, ok, acc);
    @(negedge clk);
    while (!rsp_valid[0] && budget < 50) begin @(negedge clk); budget++; end
    e = sb.pop_front();
    n_vec++;
    if (!rsp_valid[0] || !ok) begin
      n_bad++;
      $display("[TB] FAIL backpressure_wait: got valid=%b, expected 1", rsp_valid[0]);
    end
    for (int i = 0; i < 5; i++) begin
      req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 16'h0010;
      req_wdata[0] = 32'h0BADBAD0; req_be[0] = 4'hF;
      @(negedge clk);
      n_vec++;
      if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== e.rdata || rsp_err[0] !== e.err || req_ready[0] !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL backpressure_hold[%0d]: got valid=%b rdata=0x%08h err=%b ready=%b, expected 1/0x%08h/%b/0",
                 i, rsp_valid[0], rsp_rdata[0], rsp_err[0], req_ready[0], e.rdata, e.err);
      end
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[0] = 1'b0;
    @(negedge clk);
    n_vec++;
    if (rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== 32'h0 || req_ready[0] !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL backpressure_release: got valid=%b rdata=0x%08h ready=%b, expected 0/0x00000000/1",
               rsp_valid[0], rsp_rdata[0], req_ready[0]);
    end
    q.push_back(rd_op);
    run_table(0, "backpressure_after", q);
  endtask

  task automatic test_reset_mid_op();
    bit   ok;
    int   acc;
    int   budget = 0;
    op_t  rd_op = mk(1'b0, 16'h0010, 32'h0, 4'h0);
    sb.push_back(predict(0, rd_op));
    drive_req(0, rd_op, ok, acc);
    @(negedge clk);
    while (!rsp_valid[0] && budget < 50) begin @(negedge clk); budget++; end
    #2 rst_n = 1'b0;
    #1;
    void'(sb.pop_front());
    n_vec++;
    if ({req_ready[0], rsp_valid[0], rsp_err[0], rsp_rdata[0]} !== 35'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_mid_outputs: got ready=%b valid=%b err=%b rdata=0x%08h, expected all 0",
               req_ready[0], rsp_valid[0], rsp_err[0], rsp_rdata[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (req_ready[0] !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL reset_mid_ready: got %b, expected 1", req_ready[0]);
    end
  endtask

  task automatic test_reset_in_wait();
    bit   ok;
    int   acc;
    op_t  q [$];
    op_t  bad = mk(1'b1, 16'h0020, 32'hCAFEF00D, 4'hF);
    q.push_back(mk(1'b1, 16'h0020, 32'h00000000, 4'hF));
    run_table(0, "reset_wait_preload", q);
    drive_req(0, bad, ok, acc);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (!ok || rsp_valid[0] !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_wait_abort: got accepted=%b valid=%b, expected 1/0", ok, rsp_valid[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    q.push_back(mk(1'b0, 16'h0020, 32'h0, 4'h0));
    run_table(0, "reset_wait_read", q);
  endtask

  task automatic test_zero_wait();
    op_t ops [$];
    ops.push_back(mk(1'b1, 16'h0020, 32'hCAFEF00D, 4'hF));
    ops.push_back(mk(1'b0, 16'h0020, 32'h0, 4'h0));
    ops.push_back(mk(1'b1, 16'h0020, 32'h00AB00CD, 4'hA));
    ops.push_back(mk(1'b0, 16'h0020, 32'h0, 4'h0));
    ops.push_back(mk(1'b0, 16'h0400, 32'h0, 4'h0));
    run_table(1, "zero_wait", ops);
  endtask

  task automatic test_back_to_back();
    op_t ops [$];
    for (int d = 0; d < 2; d++) begin
      ops.delete();
      for (int a = 0; a < 4; a++)
        ops.push_back(mk(1'b1, 16'(16'h0030 + a), $urandom, 4'hF));
      for (int i = 0; i < 12; i++) begin
        logic [15:0] a = ($urandom_range(0, 7) == 0) ? 16'(DEPTH + $urandom_range(0, 99))
                                                     : 16'(16'h0030 + $urandom_range(0, 3));
        ops.push_back(mk(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15))));
      end
      run_table(d, (d == 0) ? "b2b_ws2" : "b2b_ws0", ops);
    end
  endtask

  initial begin
    $display("[TB] mem_responder bench start");
    test_reset();
    test_write_read();
    test_byte_enable();
    test_out_of_range();
    test_backpressure();
    test_reset_mid_op();
    test_reset_in_wait();
    test_zero_wait();
    test_back_to_back();
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
